fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  begin fetching at start_addr; sampled only in IDLE.
REQ-004 start_addr  in  16  initial program-counter value.
REQ-005 halt  in  1  stop after the current instruction is acknowledged.
REQ-006 jump, jump_addr  in  1, 16  redirect PC; sampled only in HOLD with decode_ack=1.
REQ-007 decode_ack  in  1  consumer has taken ir_out.
REQ-008 mem_ready, mem_data  in  1, 16  instruction memory read-valid and read data.
REQ-009 pc_value  in  16  data_out of the controlled PC register.
REQ-010 pc_rw, pc_inc, pc_data  out  1, 1, 16  drive the PC register: RW (1 = read to data_out, 0 = write data_in), inc (stores data_in+1, overrides RW), data_in.
REQ-011 mem_rd, mem_addr  out  1, 16  memory read request and address.
REQ-012 ir_out, ir_valid  out  16, 1  fetched instruction and its valid flag.
REQ-013 busy, err  out  1, 1  not-IDLE indicator; sticky fetch-timeout flag.

Function
REQ-014 States SHALL be IDLE, LOAD, READ_PC, LATCH, FETCH, INC, HOLD; pc_rw, pc_inc, mem_rd, ir_valid and busy SHALL be decoded from the current state only (Moore).
REQ-015 Defaults in every state unless stated: pc_rw=1, pc_inc=0, mem_rd=0, ir_valid=0; busy=1 in every state except IDLE.
REQ-016 IDLE: on start=1 -> LOAD with pc_data <= start_addr and err <= 0; start outside IDLE SHALL be ignored.
REQ-017 LOAD: pc_rw=0 for exactly one cycle; -> READ_PC.
REQ-018 READ_PC: pc_rw=1; -> LATCH.
REQ-019 LATCH: addr_reg <= pc_value; wait counter <= 0; -> FETCH.
REQ-020 FETCH: mem_rd=1 and mem_addr=addr_reg, held stable until exit.
REQ-021 FETCH: on mem_ready=1, ir_out <= mem_data; -> INC.
REQ-022 FETCH timeout: the counter increments on each FETCH cycle with mem_ready=0; if 16 consecutive cycles pass without mem_ready, err <= 1 and the block -> IDLE.
REQ-023 FETCH timeout boundary: mem_ready on the 16th cycle SHALL win over the timeout.
REQ-024 INC: pc_inc=1 and pc_data=addr_reg for one cycle, so the register stores addr_reg+1 mod 2^16 (0xFFFF wraps to 0x0000); -> HOLD.
REQ-025 HOLD: ir_valid=1 and ir_out stable until decode_ack=1.
REQ-026 HOLD exit on decode_ack, first match wins: jump=1 -> pc_data <= jump_addr, LOAD; else halt pending -> IDLE; else -> READ_PC.
REQ-027 Halt pending SHALL be set by halt=1 in any non-IDLE state, kept through HOLD, and cleared on entry to IDLE.
REQ-028 Jump wins over a pending halt on the same acknowledge; halt remains pending and takes effect at the next HOLD acknowledge.
REQ-029 Fetch latency: start sampled at edge N gives mem_rd=1 in cycle N+4; mem_ready at edge M gives ir_valid=1 in cycle M+2.
REQ-030 Steady-state throughput: with mem_ready and decode_ack both immediate, one instruction every 5 cycles.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE regardless of the current state, including mid-FETCH or mid-HOLD.
REQ-032 Reset values: pc_rw=1, pc_inc=0, pc_data=0, mem_rd=0, mem_addr=0, ir_out=0, ir_valid=0, busy=0, err=0, halt pending=0, addr_reg=0, counter=0.
REQ-033 rst SHALL override start, halt, jump and mem_ready in the same cycle.

Verification
REQ-034 start, start_addr=0x0040, mem_ready immediate, mem_data=0x1234 -> mem_addr=0x0040 in cycle 4, ir_out=0x1234 with ir_valid, PC register holds 0x0041, and the next fetch reads 0x0041.
REQ-035 start_addr=0xFFFF -> INC cycle drives pc_data=0xFFFF with pc_inc=1, and the next fetch mem_addr=0x0000.
REQ-036 In HOLD, decode_ack with jump=1, jump_addr=0x0100, and halt also pending -> LOAD writes 0x0100, the fetch at 0x0100 completes, then IDLE after its acknowledge.
REQ-037 mem_ready never asserted -> after 16 FETCH cycles err=1, busy=0, mem_rd=0; a new start clears err.
REQ-038 mem_ready on the 16th FETCH cycle -> err=0 and the instruction is delivered.
REQ-039 rst asserted during FETCH and during HOLD -> next cycle all outputs equal their reset values; start given in IDLE while decode_ack is withheld in HOLD is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads/reads an external PC register, fetches from
// instruction memory with a 16-cycle timeout, and hands each word to a decoder.
//
// state   | meaning
// IDLE    | waiting for start; busy=0
// LOAD    | write pc_data into the PC register (pc_rw=0)
// READ_PC | PC register drives its stored value on pc_value
// LATCH   | capture pc_value as the fetch address, clear wait counter
// FETCH   | memory read outstanding, timeout after 16 cycles
// INC     | PC register stores addr_reg+1
// HOLD    | instruction presented until decode_ack
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        halt,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        decode_ack,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  input  logic [15:0] pc_value,
  output logic        pc_rw,
  output logic        pc_inc,
  output logic [15:0] pc_data,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ_PC, S_LATCH, S_FETCH, S_INC, S_HOLD
  } state_t;

  state_t      state;
  logic [15:0] addr_reg;
  logic [3:0]  wait_cnt;
  logic        halt_pend;

  // Strobes are pure functions of the state register.
  assign pc_rw    = (state != S_LOAD);
  assign pc_inc   = (state == S_INC);
  assign mem_rd   = (state == S_FETCH);
  assign ir_valid = (state == S_HOLD);
  assign busy     = (state != S_IDLE);
  assign mem_addr = addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_data   <= 16'h0000;
      addr_reg  <= 16'h0000;
      ir_out    <= 16'h0000;
      wait_cnt  <= 4'd0;
      halt_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state != S_IDLE && halt)
        halt_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc_data <= start_addr;
            err     <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD:    state <= S_READ_PC;
        S_READ_PC: state <= S_LATCH;
        S_LATCH: begin
          addr_reg <= pc_value;
          wait_cnt <= 4'd0;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          // A response on the 16th cycle takes priority over the timeout.
          if (mem_ready) begin
            ir_out  <= mem_data;
            pc_data <= addr_reg;
            state   <= S_INC;
          end else if (wait_cnt == 4'd15) begin
            err       <= 1'b1;
            halt_pend <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_INC: state <= S_HOLD;
        S_HOLD: begin
          if (decode_ack) begin
            if (jump) begin
              pc_data <= jump_addr;
              state   <= S_LOAD;
            end else if (halt_pend || halt) begin
              halt_pend <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state <= S_READ_PC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC register and memory models, scoreboard
// of expected fetches, vector table plus jump/timeout/reset sequences.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, halt, jump, decode_ack;
  logic [15:0] start_addr, jump_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] pc_value;
  logic        pc_rw, pc_inc, mem_rd, ir_valid, busy, err;
  logic [15:0] pc_data, mem_addr, ir_out;

  localparam logic [15:0] KEY = 16'h5A5A;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    int          n;
    int          delay;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  int          ready_delay = 0;
  int          fcnt = 0;
  logic [15:0] fetch_addr = 16'h0000;
  logic [15:0] pc_reg = 16'h0000;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .halt(halt),
    .jump(jump), .jump_addr(jump_addr), .decode_ack(decode_ack),
    .mem_ready(mem_ready), .mem_data(mem_data), .pc_value(pc_value),
    .pc_rw(pc_rw), .pc_inc(pc_inc), .pc_data(pc_data), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .ir_out(ir_out), .ir_valid(ir_valid), .busy(busy), .err(err)
  );

  // External PC register model: inc overrides RW.
  always @(posedge clk) begin
    if (pc_inc) pc_reg <= pc_data + 16'd1;
    else if (!pc_rw) pc_reg <= pc_data;
  end
  assign pc_value = pc_reg;

  // Memory model: ready after ready_delay cycles of mem_rd, data = addr ^ KEY.
  always @(negedge clk) begin
    if (mem_rd) begin
      mem_ready = (fcnt == ready_delay);
      if (mem_ready) fetch_addr = mem_addr;
      fcnt++;
    end else begin
      mem_ready = 1'b0;
      fcnt = 0;
    end
    mem_data = mem_addr ^ KEY;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] a);
    exp_t e;
    e.addr = a;
    e.data = a ^ KEY;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctl"}, 32'({pc_rw, pc_inc, mem_rd, ir_valid, busy, err}), 32'b100000);
    chk({name, "_pc_data"}, 32'(pc_data), 32'h0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({name, "_ir_out"}, 32'(ir_out), 32'h0);
  endtask

  // Waits for ir_valid, checking latency, LOAD/INC drive values and the scoreboard head.
  task automatic wait_valid(input int exp_cycles, input bit expect_load, input logic [15:0] load_val);
    int   n = 0;
    bit   got = 1'b0;
    exp_t e;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; decode_ack = 1'b0; jump = 1'b0; halt = 1'b0;
      end
      if (!pc_rw) begin
        if (expect_load) chk("load_pc_data", 32'(pc_data), 32'(load_val));
        else chk("unexpected_load", 32'(pc_rw), 32'd1);
      end
      if (pc_inc && sb.size() > 0) chk("inc_pc_data", 32'(pc_data), 32'(sb[0].addr));
      if (ir_valid) got = 1'b1;
    end
    if (!got) begin
      chk("ir_valid_timeout", 32'(ir_valid), 32'd1);
      return;
    end
    chk("latency", 32'(n), 32'(exp_cycles));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("ir_out", 32'(ir_out), 32'(e.data));
    chk("fetch_addr", 32'(fetch_addr), 32'(e.addr));
  endtask

  // Called in HOLD: raise halt without ack, then ack; expect IDLE afterwards.
  task automatic finish_halt(input logic [15:0] exp_pc);
    halt = 1'b1; decode_ack = 1'b0;
    @(negedge clk);
    halt = 1'b0; decode_ack = 1'b1;
    chk("hold_stable_valid", 32'(ir_valid), 32'd1);
    @(negedge clk);
    decode_ack = 1'b0;
    chk("halt_idle_busy", 32'(busy), 32'd0);
    chk("halt_idle_mem_rd", 32'(mem_rd), 32'd0);
    chk("pc_after_run", 32'(pc_value), 32'(exp_pc));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; halt = 1'b0; jump = 1'b0; decode_ack = 1'b0;
    start_addr = 16'h0000; jump_addr = 16'h0000;
    vecs[0] = '{16'h0040, 2, 0};
    vecs[1] = '{16'hFFFF, 2, 0};
    vecs[2] = '{16'h1200, 3, 3};
    vecs[3] = '{16'h0ABC, 1, 15};
    vecs[4] = '{16'h7FFE, 2, 5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset_state");

    foreach (vecs[v]) begin
      ready_delay = vecs[v].delay;
      for (int i = 0; i < vecs[v].n; i++) push_exp(vecs[v].addr + 16'(i));
      start_addr = vecs[v].addr;
      start = 1'b1;
      wait_valid(6 + vecs[v].delay, 1'b1, vecs[v].addr);
      for (int i = 1; i < vecs[v].n; i++) begin
        decode_ack = 1'b1;
        wait_valid(5 + vecs[v].delay, 1'b0, 16'h0000);
      end
      chk("vec_err", 32'(err), 32'd0);
      finish_halt(vecs[v].addr + 16'(vecs[v].n));
    end

    // Jump with halt pending: jump wins, halt applies at the next acknowledge.
    ready_delay = 0;
    push_exp(16'h0200);
    start_addr = 16'h0200; start = 1'b1;
    wait_valid(6, 1'b1, 16'h0200);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; jump = 1'b1; jump_addr = 16'h0100; decode_ack = 1'b1;
    push_exp(16'h0100);
    wait_valid(6, 1'b1, 16'h0100);
    decode_ack = 1'b1;
    @(negedge clk);
    decode_ack = 1'b0;
    chk("jump_halt_busy", 32'(busy), 32'd0);
    chk("jump_pc", 32'(pc_value), 32'h0101);

    // Fetch timeout.
    ready_delay = 99;
    start_addr = 16'h0300; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end while (busy && n < 40);
    chk("timeout_cycles", 32'(n), 32'd20);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_mem_rd", 32'(mem_rd), 32'd0);
    ready_delay = 0;
    push_exp(16'h0310);
    start_addr = 16'h0310; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    wait_valid(5, 1'b0, 16'h0000);
    finish_halt(16'h0311);

    // Reset in FETCH, then in HOLD; start in HOLD is ignored.
    ready_delay = 99;
    start_addr = 16'h0400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("in_fetch", 32'(mem_rd), 32'd1);
    rst = 1'b1; start = 1'b1; halt = 1'b1;
    @(negedge clk);
    check_reset("rst_fetch");
    rst = 1'b0; start = 1'b0; halt = 1'b0;
    ready_delay = 0;
    push_exp(16'h0500);
    start_addr = 16'h0500; start = 1'b1;
    wait_valid(6, 1'b1, 16'h0500);
    start = 1'b1; start_addr = 16'h0777;
    @(negedge clk);
    start = 1'b0;
    chk("hold_ignores_start_valid", 32'(ir_valid), 32'd1);
    chk("hold_ignores_start_ir", 32'(ir_out), 32'(16'h0500 ^ KEY));
    rst = 1'b1; decode_ack = 1'b1; jump = 1'b1;
    @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b0; decode_ack = 1'b0; jump = 1'b0;
    push_exp(16'h0600);
    push_exp(16'h0601);
    start_addr = 16'h0600; start = 1'b1;
    wait_valid(6, 1'b1, 16'h0600);
    decode_ack = 1'b1;
    wait_valid(5, 1'b0, 16'h0000);
    finish_halt(16'h0602);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
